// File: rtl/forney_eval_pipe.sv
`default_nettype none
// ============================================================================
// Module   : forney_eval_pipe
// Purpose  : Forney error-magnitude evaluator for a GF(2^8) Reed-Solomon
//            decoder (field polynomial 0x11D, alpha = 0x02). For every
//            codeword position p = 0..N-1 it evaluates the error evaluator
//            Omega and the formal derivative of the error locator Lambda at
//            x_p = alpha^((p+256-N) mod 255). It produces
//            err_val = Omega(x_p) / Lambda'(x_p), additionally scaled by X_p
//            when FCR = 0. The output rate is one position per cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N   : codeword length in symbols (2T+1..255)
//   T   : correction capability (even, 2..16)
//   FCR : first consecutive root exponent (0 or 1)
// Ports
//   clk_in      in   1          rising-edge clock
//   rst_in      in   1          synchronous active-high reset
//   start       in   1          frame start; also captures lambda_odd
//   lambda_odd  in   (T/2)*8    odd locator coefficients, lambda1 in [7:0]
//   omega_in    in   8          evaluator coefficient, serial, omega0 first
//   omega_valid in   1          omega_in qualifier (accepted in LOAD only)
//   err_val     out  8          error magnitude for err_pos
//   err_pos     out  8          position index 0..N-1
//   err_valid   out  1          err_val/err_pos qualifier
//   done        out  1          pulse together with the last position
//   busy        out  1          high while a frame is in progress
//   deriv_zero  out  1          Lambda'(x_p) == 0, aligned with err_valid
// Optional feature macro: FORNEY_DERIV_ZERO_EN adds the deriv_zero port.
// ============================================================================
module forney_eval_pipe #(
    parameter int N   = 255,
    parameter int T   = 8,
    parameter int FCR = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start,
    input  logic [(T/2)*8-1:0]   lambda_odd,
    input  logic [7:0]           omega_in,
    input  logic                 omega_valid,
    output logic [7:0]           err_val,
    output logic [7:0]           err_pos,
    output logic                 err_valid,
    output logic                 done,
    output logic                 busy
`ifdef FORNEY_DERIV_ZERO_EN
    ,
    output logic                 deriv_zero
`endif
);

    localparam int L  = T / 2;
    localparam int CW = (T > 2) ? $clog2(T) : 1;
    // exponent of x_0 = alpha^((256-N) mod 255)
    localparam int E0 = (256 - N) % 255;

    // GF(2^8) multiply, polynomial 0x11D
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        r  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
        end
        return r;
    endfunction

    // b^e by square-and-multiply, e in 0..255
    function automatic logic [7:0] gf_pow(input logic [7:0] b, input int e);
        logic [7:0] r;
        logic [7:0] bb;
        r  = 8'h01;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (((e >> i) & 1) != 0) r = gf_mul(r, bb);
            bb = gf_mul(bb, bb);
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   ocnt_q;
    logic [7:0]      pos_q;
    logic            run_act_q;     // positions still being issued into stage 1

    logic [7:0]      om_q  [T];
    logic [7:0]      lam_q [L];

    // stage 1: sums
    logic            v1_q;
    logic [7:0]      om1_q, lam1_q, pos1_q;
    // stage 2: inverse lookup
    logic            v2_q;
    logic [7:0]      om2_q, inv2_q, pos2_q;

    logic [7:0]      w_x0pow    [T];
    logic [7:0]      w_om_step  [T];
    logic [7:0]      w_lam_pre  [L];
    logic [7:0]      w_lam_step [L];
    logic [7:0]      w_inv_rom  [256];
    logic [7:0]      w_om_load;
    logic [7:0]      w_om_sum;
    logic [7:0]      w_lam_sum;
    logic [7:0]      w_om2;

    // Omega terms: preload omega_j * x_0^j, advance by alpha^j per position
    for (genvar j = 0; j < T; j++) begin : g_om_term
        localparam logic [7:0] c_pre  = gf_pow(8'h02, (E0 * j) % 255);
        localparam logic [7:0] c_step = gf_pow(8'h02, j % 255);
        assign w_x0pow[j]   = c_pre;
        assign w_om_step[j] = gf_mul(om_q[j], c_step);
    end

    // Lambda' terms: lambda_(2j+1) * x^(2j)
    for (genvar j = 0; j < L; j++) begin : g_lam_term
        localparam logic [7:0] c_pre  = gf_pow(8'h02, (E0 * 2 * j) % 255);
        localparam logic [7:0] c_step = gf_pow(8'h02, (2 * j) % 255);
        assign w_lam_pre[j]  = gf_mul(lambda_odd[8*j +: 8], c_pre);
        assign w_lam_step[j] = gf_mul(lam_q[j], c_step);
    end

    // Inverse table; entry 0 maps to 0, which yields err_val = 0 for Lambda' = 0
    for (genvar g = 0; g < 256; g++) begin : g_inv_rom
        localparam logic [7:0] c_inv = gf_pow(8'(g), 254);
        assign w_inv_rom[g] = c_inv;
    end

    assign w_om_load = gf_mul(omega_in, w_x0pow[ocnt_q]);

    always_comb begin
        w_om_sum = 8'h00;
        for (int j = 0; j < T; j++) w_om_sum = w_om_sum ^ om_q[j];
    end

    always_comb begin
        w_lam_sum = 8'h00;
        for (int j = 0; j < L; j++) w_lam_sum = w_lam_sum ^ lam_q[j];
    end

    // FCR = 0 needs the extra factor X_p = x_p^-1, tracked alongside stage 1
    if (FCR == 0) begin : g_fcr0
        localparam logic [7:0] c_x_pre  = gf_pow(8'h02, (N - 1) % 255);
        localparam logic [7:0] c_x_step = gf_pow(8'h02, 254);
        logic [7:0] x_q;
        logic [7:0] x1_q;
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                x_q  <= 8'h00;
                x1_q <= 8'h00;
            end else begin
                if (state_q == S_IDLE && start) x_q <= c_x_pre;
                else if (run_act_q)             x_q <= gf_mul(x_q, c_x_step);
                if (run_act_q) x1_q <= x_q;
            end
        end
        assign w_om2 = gf_mul(om1_q, x1_q);
    end else begin : g_fcr1
        assign w_om2 = om1_q;
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            ocnt_q    <= '0;
            pos_q     <= 8'h00;
            run_act_q <= 1'b0;
            for (int j = 0; j < T; j++) om_q[j]  <= 8'h00;
            for (int j = 0; j < L; j++) lam_q[j] <= 8'h00;
            v1_q      <= 1'b0;
            om1_q     <= 8'h00;
            lam1_q    <= 8'h00;
            pos1_q    <= 8'h00;
            v2_q      <= 1'b0;
            om2_q     <= 8'h00;
            inv2_q    <= 8'h00;
            pos2_q    <= 8'h00;
            err_val   <= 8'h00;
            err_pos   <= 8'h00;
            err_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            // stage 1
            v1_q <= run_act_q;
            if (run_act_q) begin
                om1_q  <= w_om_sum;
                lam1_q <= w_lam_sum;
                pos1_q <= pos_q;
            end
            // stage 2
            v2_q <= v1_q;
            if (v1_q) begin
                om2_q  <= w_om2;
                inv2_q <= w_inv_rom[lam1_q];
                pos2_q <= pos1_q;
            end
            // stage 3: outputs hold while no new position arrives
            err_valid <= v2_q;
            done      <= v2_q && (pos2_q == 8'(N - 1));
            if (v2_q) begin
                err_val <= gf_mul(om2_q, inv2_q);
                err_pos <= pos2_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        ocnt_q  <= '0;
                        for (int j = 0; j < L; j++) lam_q[j] <= w_lam_pre[j];
                    end
                end
                S_LOAD: begin
                    if (omega_valid) begin
                        om_q[ocnt_q] <= w_om_load;
                        ocnt_q       <= ocnt_q + 1'b1;
                        if (ocnt_q == CW'(T - 1)) begin
                            state_q   <= S_RUN;
                            run_act_q <= 1'b1;
                            pos_q     <= 8'h00;
                        end
                    end
                end
                S_RUN: begin
                    if (run_act_q) begin
                        for (int j = 0; j < T; j++) om_q[j]  <= w_om_step[j];
                        for (int j = 0; j < L; j++) lam_q[j] <= w_lam_step[j];
                        pos_q <= pos_q + 8'h01;
                        if (pos_q == 8'(N - 1)) run_act_q <= 1'b0;
                    end
                    // leave once the last position has been presented
                    if (done) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FORNEY_DERIV_ZERO_EN
    logic dz2_q;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dz2_q      <= 1'b0;
            deriv_zero <= 1'b0;
        end else begin
            if (v1_q) dz2_q      <= (lam1_q == 8'h00);
            if (v2_q) deriv_zero <= dz2_q;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_forney_eval_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_forney_eval_pipe
// Purpose  : Self-checking bench for forney_eval_pipe (N=255, T=8, FCR=1).
//            Expected magnitudes come from a log/antilog GF(2^8) model that
//            evaluates the polynomials directly at every position.
// Revision : 1.0 - initial release
// ============================================================================
module tb_forney_eval_pipe;

    localparam int N   = 255;
    localparam int T   = 8;
    localparam int FCR = 1;
    localparam int L   = T / 2;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             start;
    logic [L*8-1:0]   lambda_odd;
    logic [7:0]       omega_in;
    logic             omega_valid;
    logic [7:0]       err_val;
    logic [7:0]       err_pos;
    logic             err_valid;
    logic             done;
    logic             busy;
`ifdef FORNEY_DERIV_ZERO_EN
    logic             deriv_zero;
`endif

    forney_eval_pipe #(.N(N), .T(T), .FCR(FCR)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start       (start),
        .lambda_odd  (lambda_odd),
        .omega_in    (omega_in),
        .omega_valid (omega_valid),
        .err_val     (err_val),
        .err_pos     (err_pos),
        .err_valid   (err_valid),
        .done        (done),
        .busy        (busy)
`ifdef FORNEY_DERIV_ZERO_EN
        ,
        .deriv_zero  (deriv_zero)
`endif
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- GF(2^8) reference via log/antilog tables ----------------
    int alog [256];
    int glog [256];

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return alog[(glog[a] + glog[b]) % 255];
    endfunction

    function automatic int ginv(input int a);
        return alog[(255 - glog[a]) % 255];
    endfunction

    typedef struct {
        int val;
        int pos;
        int dn;
        int dz;
    } resp_t;

    resp_t exp_q[$];
    int    cur_lam [L];
    int    cur_om  [T];

    // Expected response for every position of the current frame
    task automatic push_frame();
        for (int p = 0; p < N; p++) begin
            int e, om, ld, v;
            resp_t r;
            e  = (p + 256 - N) % 255;
            om = 0;
            ld = 0;
            for (int j = 0; j < T; j++) om ^= gmul(cur_om[j], alog[(e * j) % 255]);
            for (int j = 0; j < L; j++) ld ^= gmul(cur_lam[j], alog[(e * 2 * j) % 255]);
            v = (ld == 0) ? 0 : gmul(om, ginv(ld));
            if (FCR == 0) v = gmul(v, alog[(N - 1 - p) % 255]);
            r.val = v;
            r.pos = p;
            r.dn  = (p == N - 1) ? 1 : 0;
            r.dz  = (ld == 0) ? 1 : 0;
            exp_q.push_back(r);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int    first_cyc, done_cyc, nvalid, ndone, last_val;
    bit    seen;
    resp_t mr;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (done) ndone++;
            if (err_valid) begin
                nvalid++;
                if (!seen) begin
                    seen      = 1'b1;
                    first_cyc = cyc;
                end
                if (done) done_cyc = cyc;
                check("queue_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    mr = exp_q.pop_front();
                    last_val = mr.val;
                    check("err_val", err_val, mr.val);
                    check("err_pos", err_pos, mr.pos);
                    check("done", done, mr.dn);
`ifdef FORNEY_DERIV_ZERO_EN
                    check("deriv_zero", deriv_zero, mr.dz);
`endif
                end
            end else if (done) begin
                check("done_needs_valid", err_valid, 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    int start_cyc;

    task automatic rand_frame();
        for (int j = 0; j < L; j++) cur_lam[j] = $urandom_range(0, 255);
        for (int j = 0; j < T; j++) cur_om[j]  = $urandom_range(0, 255);
    endtask

    task automatic drive_frame(input bit gaps);
        @(posedge clk_in); #1;
        start = 1'b1;
        for (int j = 0; j < L; j++) lambda_odd[8*j +: 8] = 8'(cur_lam[j]);
        start_cyc = cyc;
        seen   = 1'b0;
        nvalid = 0;
        ndone  = 0;
        push_frame();
        @(posedge clk_in); #1;
        start = 1'b0;
        check("busy_in_load", busy, 1);
        for (int j = 0; j < T; j++) begin
            while (gaps && $urandom_range(0, 1) == 1) begin
                omega_valid = 1'b0;
                start       = 1'b1;   // stray start, must be ignored
                omega_in    = 8'($urandom_range(0, 255));
                @(posedge clk_in); #1;
            end
            start       = 1'b0;
            omega_valid = 1'b1;
            omega_in    = 8'(cur_om[j]);
            @(posedge clk_in); #1;
        end
        omega_valid = 1'b0;
        lambda_odd  = '0;
    endtask

    task automatic wait_done(input bit stray);
        int k;
        k = 0;
        while (!done && k < 2000) begin
            @(posedge clk_in); #1;
            if (stray && k < 100) begin
                start       = 1'($urandom_range(0, 1));
                omega_valid = 1'($urandom_range(0, 1));
                omega_in    = 8'($urandom_range(0, 255));
            end else begin
                start       = 1'b0;
                omega_valid = 1'b0;
            end
            @(negedge clk_in);
            k++;
        end
        check("done_seen", done, 1);
        #1;
    endtask

    task automatic timing_checks();
        check("first_valid_latency", first_cyc - start_cyc, 12);
        check("done_latency", done_cyc - start_cyc, 266);
        check("valid_count", nvalid, N);
        check("done_count", ndone, 1);
    endtask

    task automatic hold_checks();
        @(posedge clk_in); #1;
        check("busy_after_frame", busy, 0);
        check("valid_after_frame", err_valid, 0);
        check("hold_pos", err_pos, N - 1);
        check("hold_val", err_val, last_val);
    endtask

    int save_lam [L];
    int save_om  [T];
    int s1;

    initial begin
        int v;
        v = 1;
        for (int i = 0; i < 255; i++) begin
            alog[i] = v;
            glog[v] = i;
            v = v * 2;
            if (v >= 256) v = v ^ 'h11D;
        end
        alog[255] = 1;
        glog[0]   = 0;

        rst_in = 1'b1; start = 1'b0; lambda_odd = '0; omega_in = 8'h00; omega_valid = 1'b0;
        seen = 1'b0; nvalid = 0; ndone = 0; last_val = 0; first_cyc = 0; done_cyc = 0;

        // reset, with start asserted to confirm reset dominates
        repeat (2) @(posedge clk_in);
        #1 start = 1'b1;
        @(negedge clk_in);
        check("rst_err_valid", err_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err_val", err_val, 0);
        check("rst_err_pos", err_pos, 0);
        @(posedge clk_in); #1;
        check("rst_beats_start", busy, 0);
        rst_in = 1'b0;
        start  = 1'b0;

        // 1: nominal timing with random coefficients
        rand_frame();
        save_lam = cur_lam;
        save_om  = cur_om;
        drive_frame(1'b0);
        wait_done(1'b0);
        timing_checks();
        hold_checks();

        // 2: single error (expected 0x5A everywhere)
        cur_lam = '{8'h02, 0, 0, 0};
        cur_om  = '{8'hB4, 0, 0, 0, 0, 0, 0, 0};
        drive_frame(1'b0);
        wait_done(1'b0);
        timing_checks();
        hold_checks();
        check("single_error_last", last_val, 8'h5A);

        // 3: zero locator
        rand_frame();
        cur_lam = '{0, 0, 0, 0};
        drive_frame(1'b0);
        wait_done(1'b0);
        hold_checks();

        // 4: gapped load and stray control, same data as frame 1
        cur_lam = save_lam;
        cur_om  = save_om;
        drive_frame(1'b1);
        wait_done(1'b1);
        check("gapped_valid_count", nvalid, N);
        hold_checks();

        // 5: reset in the middle of a run
        rand_frame();
        drive_frame(1'b0);
        begin
            int k;
            k = 0;
            do begin
                @(negedge clk_in);
                k++;
            end while (!(err_valid && err_pos == 8'd100) && k < 400);
            check("reached_p100", err_pos, 100);
        end
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        exp_q.delete();
        nvalid = 0;
        ndone  = 0;
        repeat (300) @(negedge clk_in);
        check("no_valid_after_reset", nvalid, 0);
        check("no_done_after_reset", ndone, 0);
        check("busy_after_reset", busy, 0);
        rand_frame();
        drive_frame(1'b0);
        wait_done(1'b0);
        timing_checks();
        hold_checks();

        // 6: back-to-back frames
        rand_frame();
        drive_frame(1'b0);
        wait_done(1'b0);
        timing_checks();
        s1 = start_cyc;
        rand_frame();
        drive_frame(1'b0);   // start lands in the cycle after done
        check("b2b_start_offset", start_cyc - s1, 267);
        wait_done(1'b0);
        timing_checks();
        hold_checks();

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // absolute safety net
    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
